// File: rtl/axi_lite_sram_pkg.sv
// CPU profile constants and shared AXI4-Lite SRAM types.
// Also holds the address range helper used by both channel FSMs.
package axi_lite_sram_pkg;

  localparam int XLEN       = 32;
  localparam int AXI_STRB_W = XLEN / 8;
  localparam int WAIT_CNT_W = 3;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rd_state_e;

  // Comparing the full byte address against depth*4 is the same as comparing word index against depth.
  function automatic logic addr_in_range(input logic [XLEN-1:0] addr, input int unsigned depth_words);
    return addr < (XLEN'(depth_words) << 2);
  endfunction

endpackage

// File: rtl/axi_lite_sram_core.sv
// Word-addressed storage array with a byte-enabled write port and a registered read port.
// The array is never reset so preloaded contents survive a bus reset.
module sram_core
  import axi_lite_sram_pkg::*;
#(
  parameter int DEPTH_WORDS = 16384,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [AXI_STRB_W-1:0] wstrb,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [XLEN-1:0]       rdata
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic [XLEN-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < AXI_STRB_W; b++) begin
        if (wstrb[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // A read on the same edge as a write to the same word sees the old contents.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_lite_sram.sv
// AXI4-Lite slave in front of the unified program/data memory.
// Independent read and write FSMs, each with a programmable wait-state count.
module axi_lite_sram
  import axi_lite_sram_pkg::*;
#(
  parameter int DEPTH_WORDS = 16384,
  parameter int WAIT_STATES = 0
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [XLEN-1:0]       AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [XLEN-1:0]       WDATA,
  input  logic [AXI_STRB_W-1:0] WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [XLEN-1:0]       ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [XLEN-1:0]       RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_CNT = WAIT_CNT_W'(WAIT_STATES);

  wr_state_e                 wr_state_d, wr_state_q;
  logic [WAIT_CNT_W-1:0]     wr_cnt_d, wr_cnt_q;
  logic                      aw_cap_d, aw_cap_q, w_cap_d, w_cap_q;
  logic [XLEN-1:0]           awaddr_d, awaddr_q, wdata_d, wdata_q;
  logic [AXI_STRB_W-1:0]     wstrb_d, wstrb_q;
  logic                      awready_d, awready_q, wready_d, wready_q;
  logic                      bvalid_d, bvalid_q;
  axi_resp_e                 bresp_d, bresp_q;

  rd_state_e                 rd_state_d, rd_state_q;
  logic [WAIT_CNT_W-1:0]     rd_cnt_d, rd_cnt_q;
  logic [XLEN-1:0]           araddr_d, araddr_q;
  logic                      arready_d, arready_q;
  logic                      rvalid_d, rvalid_q;
  axi_resp_e                 rresp_d, rresp_q;

  logic                      mem_we, mem_re, wr_in_range, rd_in_range;
  logic [XLEN-1:0]           core_rdata;

  assign wr_in_range = addr_in_range(awaddr_q, DEPTH_WORDS);
  assign rd_in_range = addr_in_range(araddr_q, DEPTH_WORDS);

  // Memory enables are gated by reset so a transaction cut short by reset never commits.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    aw_cap_d   = aw_cap_q;
    w_cap_d    = w_cap_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    mem_we     = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (AWVALID && awready_q) begin
          aw_cap_d = 1'b1;
          awaddr_d = AWADDR;
        end
        if (WVALID && wready_q) begin
          w_cap_d = 1'b1;
          wdata_d = WDATA;
          wstrb_d = WSTRB;
        end
        if (aw_cap_d && w_cap_d) begin
          wr_state_d = W_WAIT;
          wr_cnt_d   = WAIT_CNT;
        end
      end
      W_WAIT: begin
        if (wr_cnt_q == '0) begin
          mem_we     = ARESETn && wr_in_range;
          bresp_d    = wr_in_range ? RESP_OKAY : RESP_SLVERR;
          bvalid_d   = 1'b1;
          wr_state_d = W_RESP;
        end else begin
          wr_cnt_d = wr_cnt_q - 3'd1;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          bvalid_d   = 1'b0;
          aw_cap_d   = 1'b0;
          w_cap_d    = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
    awready_d = (wr_state_d == W_IDLE) && !aw_cap_d;
    wready_d  = (wr_state_d == W_IDLE) && !w_cap_d;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_state_q <= W_IDLE;
      wr_cnt_q   <= '0;
      aw_cap_q   <= 1'b0;
      w_cap_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      aw_cap_q   <= aw_cap_d;
      w_cap_q    <= w_cap_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    araddr_d   = araddr_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    mem_re     = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (ARVALID && arready_q) begin
          araddr_d   = ARADDR;
          rd_cnt_d   = WAIT_CNT;
          rd_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rd_cnt_q == '0) begin
          mem_re     = ARESETn && rd_in_range;
          rresp_d    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
          rvalid_d   = 1'b1;
          rd_state_d = R_DATA;
        end else begin
          rd_cnt_d = rd_cnt_q - 3'd1;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    arready_d = (rd_state_d == R_IDLE);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rd_state_q <= R_IDLE;
      rd_cnt_q   <= '0;
      araddr_q   <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      araddr_q   <= araddr_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
    end
  end

  sram_core #(.DEPTH_WORDS(DEPTH_WORDS)) mem0 (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .we    (mem_we),
    .waddr (awaddr_q[IDX_W+1:2]),
    .wdata (wdata_q),
    .wstrb (wstrb_q),
    .re    (mem_re),
    .raddr (araddr_q[IDX_W+1:2]),
    .rdata (core_rdata)
  );

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  // Error responses always carry zero data.
  assign RDATA   = (rresp_q == RESP_SLVERR) ? '0 : core_rdata;

endmodule

// File: tb/tb_axi_lite_sram.sv
// Self-checking bench for axi_lite_sram: directed vector table, hand-written corner sequences
// and a randomized phase checked against a word-array reference model.
module tb_axi_lite_sram;

  localparam int DEPTH = 16384;
  localparam int BOUND = 40;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic [3:0]  WSTRB;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;

  logic        awready0, wready0, bvalid0, arready0, rvalid0;
  logic [1:0]  bresp0, rresp0;
  logic [31:0] rdata0;
  logic        awready3, wready3, bvalid3, arready3, rvalid3;
  logic [1:0]  bresp3, rresp3;
  logic [31:0] rdata3;

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  bit          use3 = 1'b0;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] ref_mem [32];

  always #5 ACLK = ~ACLK;

  axi_lite_sram #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(awready0),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(wready0),
    .BRESP(bresp0), .BVALID(bvalid0), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(arready0),
    .RDATA(rdata0), .RRESP(rresp0), .RVALID(rvalid0), .RREADY(RREADY)
  );

  axi_lite_sram #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut3 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(awready3),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(wready3),
    .BRESP(bresp3), .BVALID(bvalid3), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(arready3),
    .RDATA(rdata3), .RRESP(rresp3), .RVALID(rvalid3), .RREADY(RREADY)
  );

  // Both instances share inputs; the bench observes whichever one is selected.
  always_comb begin
    if (use3) begin
      awready = awready3; wready = wready3; bvalid = bvalid3; arready = arready3;
      rvalid = rvalid3; bresp = bresp3; rresp = rresp3; rdata = rdata3;
    end else begin
      awready = awready0; wready = wready0; bvalid = bvalid0; arready = arready0;
      rvalid = rvalid0; bresp = bresp0; rresp = rresp0; rdata = rdata0;
    end
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    string       name;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_total++;
    n_bad++;
    $display("[TB] FAIL %s: timeout after %0d cycles", name, BOUND);
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    dut0.mem0.mem[idx] = val;
    dut3.mem0.mem[idx] = val;
    ref_mem[idx] = val;
  endtask

  // Reference model: byte-masked merge into a word array, anything past DEPTH is an error.
  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] mask;
    int unsigned idx;
    idx  = addr / 4;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    if (idx >= DEPTH) return 2'b10;
    if (idx < 32) ref_mem[idx] = (ref_mem[idx] & ~mask) | (data & mask);
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int unsigned idx;
    idx = addr / 4;
    if (idx >= DEPTH) return 32'h0;
    return ref_mem[idx];
  endfunction

  task automatic do_reset(input int cycles);
    ARESETn = 1'b0;
    repeat (cycles) tick();
    ARESETn = 1'b1;
    tick();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int stall, output logic [1:0] resp, output int lat);
    bit a, w;
    int n;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = (stall == 0);
    n = 0;
    while ((AWVALID || WVALID) && n < BOUND) begin
      a = awready; w = wready;
      tick(); n++;
      if (a) AWVALID = 1'b0;
      if (w) WVALID = 1'b0;
    end
    lat = 1;
    while (!bvalid && lat < BOUND) begin
      tick(); lat++;
    end
    if (!bvalid) timeout("wr_bvalid");
    resp = bresp;
    repeat (stall) tick();
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    AWVALID = 1'b0; WVALID = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int stall,
                         output logic [31:0] data, output logic [1:0] resp, output int lat);
    bit r;
    int n;
    ARADDR = addr; ARVALID = 1'b1; RREADY = (stall == 0);
    n = 0;
    while (ARVALID && n < BOUND) begin
      r = arready;
      tick(); n++;
      if (r) ARVALID = 1'b0;
    end
    lat = 1;
    while (!rvalid && lat < BOUND) begin
      tick(); lat++;
    end
    if (!rvalid) timeout("rd_rvalid");
    data = rdata; resp = rresp;
    repeat (stall) tick();
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    ARVALID = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [31:0] d;
    logic [1:0]  r, dummy;
    int          lat;
    if (v.wr) begin
      do_write(v.addr, v.data, v.strb, 0, r, lat);
      dummy = model_write(v.addr, v.data, v.strb);
      checkOutput({v.name, "_bresp"}, {30'd0, r}, {30'd0, v.exp_resp});
      checkOutput({v.name, "_blat"}, lat, 2);
    end else begin
      do_read(v.addr, 0, d, r, lat);
      checkOutput({v.name, "_rdata"}, d, v.exp_data);
      checkOutput({v.name, "_rresp"}, {30'd0, r}, {30'd0, v.exp_resp});
      checkOutput({v.name, "_rlat"}, lat, 2);
    end
  endtask

  initial begin
    logic [31:0] d, addr, data, exp_d;
    logic [1:0]  r, exp_r;
    logic [3:0]  strb;
    int          lat, rlat, blat, n, errs, seen;
    bit          a, w, ar;

    ARESETn = 1'b0;
    AWADDR = '0; WDATA = '0; WSTRB = '0; ARADDR = '0;
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;

    for (int i = 0; i < 32; i++) preload(i, $urandom);
    preload(0, 32'h0123_4567);
    preload(1, 32'h1111_1111);
    preload(2, 32'h2222_2222);
    preload(4, 32'hDEAD_BEEF);
    preload(8, 32'hAAAA_AAAA);

    vecs[0] = '{1'b0, 32'h10,    32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00, "rd_preload"};
    vecs[1] = '{1'b1, 32'h10000, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b10, "wr_oor"};
    vecs[2] = '{1'b0, 32'h10000, 32'h0,         4'h0, 32'h0,         2'b10, "rd_oor"};
    vecs[3] = '{1'b1, 32'h4,     32'hCAFE_F00D, 4'h3, 32'h0,         2'b00, "wr_lo_half"};
    vecs[4] = '{1'b0, 32'h4,     32'h0,         4'h0, 32'h1111_F00D, 2'b00, "rd_lo_half"};
    vecs[5] = '{1'b0, 32'h7,     32'h0,         4'h0, 32'h1111_F00D, 2'b00, "rd_unaligned"};
    vecs[6] = '{1'b0, 32'h0,     32'h0,         4'h0, 32'h0123_4567, 2'b00, "rd_alias0"};
    vecs[7] = '{1'b1, 32'h8,     32'hFFFF_FFFF, 4'h0, 32'h0,         2'b00, "wr_nostrb"};
    vecs[8] = '{1'b0, 32'h8,     32'h0,         4'h0, 32'h2222_2222, 2'b00, "rd_nostrb"};

    // Reset values
    repeat (2) tick();
    checkOutput("rst_awready", {31'd0, awready}, 0);
    checkOutput("rst_wready",  {31'd0, wready},  0);
    checkOutput("rst_arready", {31'd0, arready}, 0);
    checkOutput("rst_bvalid",  {31'd0, bvalid},  0);
    checkOutput("rst_rvalid",  {31'd0, rvalid},  0);
    checkOutput("rst_bresp",   {30'd0, bresp},   0);
    checkOutput("rst_rresp",   {30'd0, rresp},   0);
    checkOutput("rst_rdata",   rdata,            0);
    ARESETn = 1'b1;
    tick();
    checkOutput("post_rst_awready", {31'd0, awready}, 1);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);
    checkOutput("oor_no_alias_write", dut0.mem0.mem[0], 32'h0123_4567);

    // W before AW, WREADY must drop once W is held
    WDATA = 32'h1122_3344; WSTRB = 4'b0101; WVALID = 1'b1; BREADY = 1'b1;
    tick();
    WVALID = 1'b0;
    tick();
    checkOutput("w_first_wready_low", {31'd0, wready}, 0);
    AWADDR = 32'h20; AWVALID = 1'b1;
    a = awready;
    tick();
    AWVALID = 1'b0;
    checkOutput("w_first_aw_taken", {31'd0, a}, 1);
    lat = 1;
    while (!bvalid && lat < BOUND) begin tick(); lat++; end
    checkOutput("w_first_blat", lat, 2);
    checkOutput("w_first_bresp", {30'd0, bresp}, 0);
    tick();
    BREADY = 1'b0;
    r = model_write(32'h20, 32'h1122_3344, 4'b0101);
    do_read(32'h20, 0, d, r, lat);
    checkOutput("w_first_readback", d, 32'hAA22_AA44);

    // BREADY held low: response and AWREADY must stay put
    AWADDR = 32'h24; WDATA = 32'h0BAD_F00D; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    n = 0;
    while (!bvalid && n < BOUND) begin tick(); n++; end
    if (!bvalid) timeout("bhold_bvalid");
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0) errs++;
      tick();
    end
    checkOutput("bhold_stable", errs, 0);
    BREADY = 1'b1;
    checkOutput("bhold_awready_at_hs", {31'd0, awready}, 0);
    tick();
    BREADY = 1'b0;
    checkOutput("bhold_awready_after", {31'd0, awready}, 1);
    r = model_write(32'h24, 32'h0BAD_F00D, 4'hF);

    // Randomized traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      addr = $urandom_range(0, 31) * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) addr = addr + 32'h10000;
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        do_write(addr, data, strb, $urandom_range(0, 3), r, lat);
        exp_r = model_write(addr, data, strb);
        checkOutput("rand_bresp", {30'd0, r}, {30'd0, exp_r});
      end else begin
        exp_d = model_read(addr);
        exp_r = (addr >= 32'h10000) ? 2'b10 : 2'b00;
        do_read(addr, $urandom_range(0, 3), d, r, lat);
        checkOutput("rand_rdata", d, exp_d);
        checkOutput("rand_rresp", {30'd0, r}, {30'd0, exp_r});
        checkOutput("rand_rlat", lat, 2);
      end
    end

    // WAIT_STATES=3 instance: same-cycle write and read of one word
    do_reset(2);
    use3 = 1'b1;
    dut3.mem0.mem[12] = 32'h9;
    dut3.mem0.mem[4]  = 32'hDEAD_BEEF;
    AWADDR = 32'h30; WDATA = 32'h5; WSTRB = 4'hF; ARADDR = 32'h30;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1; BREADY = 1'b1; RREADY = 1'b1;
    a = awready; w = wready; ar = arready;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    checkOutput("collide_handshake", {29'd0, a, w, ar}, 32'h7);
    n = 1; rlat = 0; blat = 0; d = '0; r = '0;
    while ((rlat == 0 || blat == 0) && n < BOUND) begin
      if (rvalid && rlat == 0) begin rlat = n; d = rdata; r = rresp; end
      if (bvalid && blat == 0) blat = n;
      tick(); n++;
    end
    BREADY = 1'b0; RREADY = 1'b0;
    checkOutput("collide_rlat", rlat, 5);
    checkOutput("collide_blat", blat, 5);
    checkOutput("collide_rdata_old", d, 32'h9);
    checkOutput("collide_rresp", {30'd0, r}, 0);
    tick();
    do_read(32'h30, 0, d, r, lat);
    checkOutput("collide_readback", d, 32'h5);
    checkOutput("ws3_rlat", lat, 5);

    // Reset in R_WAIT drops the read
    ARADDR = 32'h10; ARVALID = 1'b1; RREADY = 1'b1;
    tick();
    ARVALID = 1'b0;
    tick();
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (rvalid) seen++;
      tick();
    end
    RREADY = 1'b0;
    checkOutput("rst_rd_no_rvalid", seen, 0);
    checkOutput("rst_rd_arready", {31'd0, arready}, 1);
    checkOutput("rst_rd_mem_kept", dut3.mem0.mem[4], 32'hDEAD_BEEF);

    // Reset in W_WAIT on the zero-wait instance must not commit the write
    use3 = 1'b0;
    AWADDR = 32'h14; WDATA = ~ref_mem[5]; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bvalid) seen++;
      tick();
    end
    BREADY = 1'b0;
    checkOutput("rst_wr_no_bvalid", seen, 0);
    checkOutput("rst_wr_mem_kept", dut0.mem0.mem[5], ref_mem[5]);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_sram.md
Name: axi_lite_sram

Overview:
- AXI4-Lite slave that fronts the unified word-addressed program/data memory. Sits directly downstream of the top-level AXI interconnect.
- Serves CPU instruction fetches, loads and stores.
- Owns the storage array that the simulation bench preloads with `$readmemh` and inspects at end of test.
- Independent read and write channels with a programmable wait-state count, to exercise CPU stall paths.

Parameters:
- XLEN, 32, data/address width; taken from the CPU_profile package.
- DEPTH_WORDS, 16384, number of 32-bit words in the array (64 KiB).
- WAIT_STATES, 0, extra cycles between request acceptance and response (0..7).

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  synchronous active-low reset.
- AWADDR  in  XLEN  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  XLEN  write data.
- WSTRB  in  XLEN/8  byte enables.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response (00 OKAY, 10 SLVERR).
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  XLEN  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  XLEN  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.

Behaviour:
- Clock and reset: one clock, ACLK. Reset ARESETn is synchronous and active-low.
- Storage:
  - Array `logic [XLEN-1:0] mem [DEPTH_WORDS]`, named exactly `mem` (bench backdoor path).
  - Indexed by addr[XLEN-1:2]; addr[1:0] ignored.
  - Never reset, so preloaded contents survive ARESETn.
- Reset values:
  - AWREADY, WREADY, ARREADY, BVALID and RVALID are 0.
  - BRESP, RRESP and RDATA are 0.
  - Both FSMs return to IDLE. Reset mid-transaction drops the transaction and performs no memory write.
- Write FSM (W_IDLE, W_WAIT, W_RESP):
  - W_IDLE: AWREADY=1 until AW is captured; WREADY=1 until W is captured. AW and W may arrive in any order or in the same cycle; each is held in a register.
  - When both are captured, go to W_WAIT with counter = WAIT_STATES.
  - W_WAIT: decrement the counter each cycle. On the cycle the counter is 0:
    - In-range address: write the bytes whose WSTRB bit is 1, then go to W_RESP.
    - Out-of-range address (index >= DEPTH_WORDS): drop the write and set BRESP=10.
  - W_RESP: BVALID=1, held stable until BREADY is sampled high; then go to W_IDLE (AWREADY/WREADY high the next cycle).
  - Latency: with WAIT_STATES=0, BVALID rises 2 cycles after the later of the AW/W handshakes.
- Read FSM (R_IDLE, R_WAIT, R_DATA):
  - R_IDLE: ARREADY=1. On the handshake, latch the address and go to R_WAIT with counter = WAIT_STATES.
  - R_WAIT: on the cycle the counter is 0, register RDATA=mem[idx] and go to R_DATA.
    - Out-of-range address: RDATA=0, RRESP=10.
  - R_DATA: RVALID=1 with RDATA/RRESP stable until RREADY; then go to R_IDLE.
  - Latency: with WAIT_STATES=0, RVALID rises 2 cycles after the AR handshake.
- Read/write collision: if a write commits and a read samples the same word in the same cycle, the read returns the pre-write value. The write is visible to any later read.
- One outstanding transaction per channel. The read and write channels are fully concurrent.

Decomposition:
- Add to the CPU_profile package:
  - `axi_resp_e` (OKAY/SLVERR).
  - FSM state enums `wr_state_e` and `rd_state_e`.
  - Constant `AXI_STRB_W = XLEN/8`.
- One sub-module: `sram_core`, holding the array `mem` plus the byte-enabled synchronous write and registered read port. The instance name `mem0` keeps the bench path `mem0.mem`.
- FSMs and wait counters live in the top module.

Test Plan:
- Preload mem[4]=0xDEADBEEF, WAIT_STATES=0, AR 0x10 with RREADY=1 -> RVALID exactly 2 cycles after the AR handshake, RDATA=0xDEADBEEF, RRESP=00.
- W before AW: WDATA=0x11223344, WSTRB=0101, then AWADDR=0x20 (mem[8] preloaded with 0xAAAAAAAA) -> BRESP=00; readback of 0x20 returns 0xAA22AA44.
- BREADY held low for 5 cycles after a write -> BVALID/BRESP stable for all 5 cycles; AWREADY stays 0 until one cycle after the B handshake.
- AWADDR=DEPTH_WORDS*4 and ARADDR=DEPTH_WORDS*4 -> BRESP=10 with no array change; RRESP=10 with RDATA=0.
- WAIT_STATES=3, simultaneous write 0x5 and read of the same word (old value 0x9) -> RDATA=0x9 with RVALID 5 cycles after AR; a following read returns 0x5.
- ARESETn low for 1 cycle during R_WAIT -> RVALID never asserts; ARREADY returns to 1 after reset; the preloaded word is unchanged.
